axi_burst_gen: RTL

//  Expands one AXI AR/AW burst request into a stream of per-beat addresses.

---
 rtl/axi_burst_gen_pkg.sv | 9 +
 rtl/axi_pkg.sv | 24 ++
 rtl/axi_burst_gen_if.sv | 34 +++
 rtl/axi_beat_addr_calc.sv | 31 +++
 rtl/axi_burst_gen.sv | 133 +++++++++++++
 5 files changed

// File: rtl/axi_burst_gen_pkg.sv
// Local types for axi_burst_gen: FSM state encoding and page geometry.
package axi_burst_gen_pkg;
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_e;

  localparam int PageBits = 12;
endpackage

// File: rtl/axi_pkg.sv
// AXI burst/response encodings shared by the burst generator and its backends.
package axi_pkg;
  typedef logic [1:0]  burst_t;
  typedef logic [1:0]  resp_t;
  typedef logic [7:0]  len_t;
  typedef logic [2:0]  size_t;
  typedef logic [63:0] addr_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;
  localparam burst_t BURST_RSVD  = 2'b11;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  function automatic addr_t num_bytes(size_t size);
    return addr_t'(1) << size;
  endfunction

  function automatic addr_t aligned_addr(addr_t addr, size_t size);
    return addr & ~(num_bytes(size) - addr_t'(1));
  endfunction
endpackage

// File: rtl/axi_burst_gen_if.sv
// Request (ax_*) and per-beat (beat_*) channels of axi_burst_gen.
interface axi_burst_gen_if
  import axi_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 4
);
  logic                 ax_valid_i;
  logic                 ax_ready_o;
  logic [IdWidth-1:0]   ax_id_i;
  logic [AddrWidth-1:0] ax_addr_i;
  len_t                 ax_len_i;
  size_t                ax_size_i;
  burst_t               ax_burst_i;
  logic                 beat_valid_o;
  logic                 beat_ready_i;
  logic [IdWidth-1:0]   beat_id_o;
  logic [AddrWidth-1:0] beat_addr_o;
  len_t                 beat_idx_o;
  logic                 beat_last_o;
  resp_t                beat_resp_o;

  modport slave (
    input  ax_valid_i, ax_id_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, beat_ready_i,
    output ax_ready_o, beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o,
           beat_resp_o
  );

  modport master (
    output ax_valid_i, ax_id_i, ax_addr_i, ax_len_i, ax_size_i, ax_burst_i, beat_ready_i,
    input  ax_ready_o, beat_valid_o, beat_id_o, beat_addr_o, beat_idx_o, beat_last_o,
           beat_resp_o
  );
endinterface

// File: rtl/axi_beat_addr_calc.sv
// Combinational address of the beat following addr_i for FIXED/INCR/WRAP bursts.
module axi_beat_addr_calc
  import axi_pkg::*;
#(
  parameter int AddrWidth = 64
) (
  input  logic [AddrWidth-1:0] addr_i,
  input  size_t                size_i,
  input  len_t                 len_i,
  input  burst_t               burst_i,
  output logic [AddrWidth-1:0] next_addr_o
);
  logic [AddrWidth-1:0] nb;
  logic [AddrWidth-1:0] aligned;
  logic [AddrWidth-1:0] incr;
  logic [AddrWidth-1:0] wsize;
  logic [AddrWidth-1:0] lower;

  always_comb begin
    nb      = AddrWidth'(num_bytes(size_i));
    aligned = AddrWidth'(aligned_addr(addr_t'(addr_i), size_i));
    incr    = aligned + nb;
    wsize   = (AddrWidth'(len_i) + AddrWidth'(1)) << size_i;
    lower   = addr_i & ~(wsize - AddrWidth'(1));
    case (burst_i)
      BURST_INCR: next_addr_o = incr;
      BURST_WRAP: next_addr_o = (incr == lower + wsize) ? lower : incr;
      default:    next_addr_o = addr_i;
    endcase
  end
endmodule

// File: rtl/axi_burst_gen.sv
// Expands one AXI AR/AW request into per-beat addresses; illegal bursts beat out SLVERR.
// Optional macro AXI_BURST_GEN_4K_CHECK_EN makes INCR bursts crossing a 4 KiB page illegal.
//   state    | meaning
//   ST_IDLE  | no burst held, request channel ready
//   ST_BURST | presenting beat idx_q of the latched request
module axi_burst_gen
  import axi_pkg::*;
  import axi_burst_gen_pkg::*;
#(
  parameter int AddrWidth = 64,
  parameter int IdWidth   = 4,
  parameter int DataWidth = 64
) (
  input logic            clk_i,
  input logic            rst_i,
  axi_burst_gen_if.slave bus
);
  localparam size_t MaxSize = size_t'($clog2(DataWidth / 8));

  state_e               state_q, state_d;
  logic [IdWidth-1:0]   id_q, id_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [AddrWidth-1:0] next_addr;
  len_t                 idx_q, idx_d;
  len_t                 len_q, len_d;
  size_t                size_q, size_d;
  burst_t               burst_q, burst_d;
  resp_t                resp_q, resp_d;
  logic                 last_q, last_d;
  logic                 beat_hs;
  logic                 ax_ready;
  logic                 illegal;
  logic                 page_bad;

`ifdef AXI_BURST_GEN_4K_CHECK_EN
  logic [AddrWidth-1:0] final_byte;

  always_comb begin
    final_byte = AddrWidth'(aligned_addr(addr_t'(bus.ax_addr_i), bus.ax_size_i))
               + ((AddrWidth'(bus.ax_len_i) + AddrWidth'(1)) << bus.ax_size_i)
               - AddrWidth'(1);
    page_bad   = (bus.ax_burst_i == BURST_INCR) &&
                 (final_byte[AddrWidth-1:PageBits] != bus.ax_addr_i[AddrWidth-1:PageBits]);
  end
`else
  assign page_bad = 1'b0;
`endif

  always_comb begin
    illegal = (bus.ax_size_i > MaxSize) || (bus.ax_burst_i == BURST_RSVD) || page_bad;
    if ((bus.ax_burst_i == BURST_WRAP) &&
        !(bus.ax_len_i inside {8'd1, 8'd3, 8'd7, 8'd15})) begin
      illegal = 1'b1;
    end
  end

  // Illegal bursts are latched as FIXED so the address never moves.
  axi_beat_addr_calc #(
    .AddrWidth(AddrWidth)
  ) u_addr_calc (
    .addr_i     (addr_q),
    .size_i     (size_q),
    .len_i      (len_q),
    .burst_i    (burst_q),
    .next_addr_o(next_addr)
  );

  assign beat_hs  = (state_q == ST_BURST) & bus.beat_ready_i;
  assign ax_ready = (state_q == ST_IDLE) | (beat_hs & last_q);

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    idx_d   = idx_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    resp_d  = resp_q;
    last_d  = last_q;
    if (bus.ax_valid_i && ax_ready) begin
      state_d = ST_BURST;
      id_d    = bus.ax_id_i;
      addr_d  = bus.ax_addr_i;
      idx_d   = '0;
      len_d   = bus.ax_len_i;
      size_d  = bus.ax_size_i;
      burst_d = illegal ? BURST_FIXED : bus.ax_burst_i;
      resp_d  = illegal ? RESP_SLVERR : RESP_OKAY;
      last_d  = (bus.ax_len_i == 8'd0);
    end else if (beat_hs) begin
      if (last_q) begin
        state_d = ST_IDLE;
      end else begin
        idx_d  = idx_q + 8'd1;
        addr_d = next_addr;
        last_d = ((idx_q + 8'd1) == len_q);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= BURST_FIXED;
      resp_q  <= RESP_OKAY;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      resp_q  <= resp_d;
      last_q  <= last_d;
    end
  end

  assign bus.ax_ready_o   = ax_ready;
  assign bus.beat_valid_o = (state_q == ST_BURST);
  assign bus.beat_id_o    = id_q;
  assign bus.beat_addr_o  = addr_q;
  assign bus.beat_idx_o   = idx_q;
  assign bus.beat_last_o  = last_q;
  assign bus.beat_resp_o  = resp_q;
endmodule
